// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares the 16-bit processor's single memory port between the instruction
// fetch path (IF) and the load/store path (LS). It drives a fixed-latency
// memory and captures read data into RD_DATA.
//
// Each accepted access runs through three states:
//   IDLE -> ACCESS (MEM_LAT cycles) -> DONE (1 cycle) -> IDLE
// GNT pulses in the first ACCESS cycle. DONE pulses in the DONE state.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : on a tie, the requester that did not win last time wins.
//               History resets to "LS last".
//   undefined : on a tie, LS always wins. No history register is built.
//
// MEM_LAT must be in 1..15 so that it fits the 4-bit access counter.

module memory_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch requester
  input  logic        IF_REQ,
  input  logic [15:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_DONE,
  // load/store requester
  input  logic        LS_REQ,
  input  logic        LS_WE,
  input  logic [15:0] LS_ADDR,
  input  logic [15:0] LS_WDATA,
  output logic        LS_GNT,
  output logic        LS_DONE,
  // memory port
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  // held read result
  output logic [15:0] RD_DATA
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  // Bit positions of the per-requester pulse vectors.
  localparam int REQ_IF = 0;
  localparam int REQ_LS = 1;

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;        // 1 = LS owns the current access
  logic        mem_en_reg, mem_en_next;
  logic        mem_we_reg, mem_we_next;      // doubles as the latched write flag
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [15:0] mem_wdata_reg, mem_wdata_next;
  logic [15:0] rd_data_reg, rd_data_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic [1:0]  done_reg, done_next;

  logic        any_req;
  logic        pick_ls;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_ls_reg, last_ls_next;    // 1 = LS won the previous grant
`endif

  // Choose the winner among the pending requests (only acted on in IDLE).
  always_comb begin
    any_req = IF_REQ | LS_REQ;
`ifdef ARB_ROUND_ROBIN_EN
    if (IF_REQ && LS_REQ) begin
      pick_ls = ~last_ls_reg;
    end else begin
      pick_ls = LS_REQ;
    end
`else
    pick_ls = LS_REQ;
`endif
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which requester took the most recent grant.
  always_comb begin
    last_ls_next = last_ls_reg;
    if (state_reg == ST_IDLE && any_req) begin
      last_ls_next = pick_ls;
    end
  end

  // History register; after reset, LS counts as the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls_reg <= 1'b1;
    end else begin
      last_ls_reg <= last_ls_next;
    end
  end
`endif

  // Sequencer: next state, the access counter, and every registered output.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    owner_next     = owner_reg;
    mem_en_next    = mem_en_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rd_data_next   = rd_data_reg;
    gnt_next       = 2'b00;
    done_next      = 2'b00;

    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next    = ST_ACCESS;
          cnt_next      = LAT_LOAD;
          owner_next    = pick_ls;
          mem_en_next   = 1'b1;
          // A fetch is always a read.
          mem_we_next   = pick_ls & LS_WE;
          mem_addr_next = pick_ls ? LS_ADDR : IF_ADDR;
          // A fetch carries no write data, so the bus keeps its last value.
          if (pick_ls) begin
            mem_wdata_next = LS_WDATA;
          end
          gnt_next = pick_ls ? 2'b10 : 2'b01;
        end
      end

      ST_ACCESS: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          // Last ACCESS cycle: the memory data is valid now.
          state_next  = ST_DONE;
          mem_en_next = 1'b0;
          mem_we_next = 1'b0;
          if (!mem_we_reg) begin
            rd_data_next = MEM_RDATA;
          end
          done_next[owner_reg] = 1'b1;
        end
      end

      ST_DONE: begin
        // No arbitration here; a request still pending is taken from IDLE.
        state_next = ST_IDLE;
      end

      default: begin
        state_next  = ST_IDLE;
        mem_en_next = 1'b0;
        mem_we_next = 1'b0;
      end
    endcase
  end

  // Control registers: state, counter, and the owner of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      owner_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
    end
  end

  // Memory-port and read-result registers; reset also clears the bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 16'h0000;
      mem_wdata_reg <= 16'h0000;
      rd_data_reg   <= 16'h0000;
    end else begin
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rd_data_reg   <= rd_data_next;
    end
  end

  // Grant and done pulses; reset drops an in-flight access with no DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg  <= 2'b00;
      done_reg <= 2'b00;
    end else begin
      gnt_reg  <= gnt_next;
      done_reg <= done_next;
    end
  end

  assign IF_GNT    = gnt_reg[REQ_IF];
  assign LS_GNT    = gnt_reg[REQ_LS];
  assign IF_DONE   = done_reg[REQ_IF];
  assign LS_DONE   = done_reg[REQ_LS];
  assign MEM_EN    = mem_en_reg;
  assign MEM_WE    = mem_we_reg;
  assign MEM_ADDR  = mem_addr_reg;
  assign MEM_WDATA = mem_wdata_reg;
  assign RD_DATA   = rd_data_reg;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter
// Two copies of the arbiter share one stimulus stream:
//   - index 0 uses MEM_LAT=2
//   - index 1 uses MEM_LAT=1
// A reference model tracks each access by the cycle in which it was accepted.
// From that cycle offset it derives every expected output.
// Directed scenarios come first, followed by a randomized stretch.

module tb_memory_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr, ls_wdata, mem_rdata;

  logic [1:0]  if_gnt, if_done, ls_gnt, ls_done, mem_en, mem_we;
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] rd_data [2];

  memory_port_arbiter #(.MEM_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt[0]), .IF_DONE(if_done[0]),
    .LS_REQ(ls_req), .LS_WE(ls_we), .LS_ADDR(ls_addr), .LS_WDATA(ls_wdata),
    .LS_GNT(ls_gnt[0]), .LS_DONE(ls_done[0]),
    .MEM_EN(mem_en[0]), .MEM_WE(mem_we[0]), .MEM_ADDR(mem_addr[0]),
    .MEM_WDATA(mem_wdata[0]), .MEM_RDATA(mem_rdata), .RD_DATA(rd_data[0])
  );

  memory_port_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt[1]), .IF_DONE(if_done[1]),
    .LS_REQ(ls_req), .LS_WE(ls_we), .LS_ADDR(ls_addr), .LS_WDATA(ls_wdata),
    .LS_GNT(ls_gnt[1]), .LS_DONE(ls_done[1]),
    .MEM_EN(mem_en[1]), .MEM_WE(mem_we[1]), .MEM_ADDR(mem_addr[1]),
    .MEM_WDATA(mem_wdata[1]), .MEM_RDATA(mem_rdata), .RD_DATA(rd_data[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_rdata = 1'b0;

  // Reference model: one in-flight access per instance, located in time by m_c0.
  bit          m_busy    [2];
  int          m_c0      [2];
  bit          m_ls      [2];
  bit          m_wr      [2];
  logic [15:0] m_addr    [2];
  logic [15:0] m_wdata   [2];
  logic [15:0] m_rd      [2];
  bit          m_last_ls [2];

  // Logs used by the directed checks.
  bit q_gnt0 [$];          // grant order of the MEM_LAT=2 copy (1 = LS)
  int q_if_gnt1 [$];       // cycles of IF_GNT on the MEM_LAT=1 copy
  int q_if_done1 [$];      // cycles of IF_DONE on the MEM_LAT=1 copy
  int n_ls_gnt0  = 0;
  int n_ls_done0 = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the rules for the cycle `cyc` that ends on this rising edge.
  task automatic model_edge(input int i);
    int  k;
    bit  pick_ls;
    if (rst) begin
      m_busy[i]    = 1'b0;
      m_rd[i]      = 16'h0000;
      m_addr[i]    = 16'h0000;
      m_wdata[i]   = 16'h0000;
      m_last_ls[i] = 1'b1;
    end else if (!m_busy[i]) begin
      if (if_req || ls_req) begin
        if (if_req && ls_req) pick_ls = RR ? !m_last_ls[i] : 1'b1;
        else                  pick_ls = ls_req;
        m_busy[i]    = 1'b1;
        m_c0[i]      = cyc;
        m_ls[i]      = pick_ls;
        m_wr[i]      = pick_ls && ls_we;
        m_addr[i]    = pick_ls ? ls_addr : if_addr;
        if (pick_ls) m_wdata[i] = ls_wdata;
        m_last_ls[i] = pick_ls;
      end
    end else begin
      k = cyc - m_c0[i];
      if (k == lat_of(i) && !m_wr[i]) m_rd[i] = mem_rdata;
      if (k == lat_of(i) + 1)         m_busy[i] = 1'b0;
    end
  endtask

  // Compare one instance's outputs with the model for the current cycle.
  task automatic check(input int i);
    int k;
    int l;
    bit en, we, gi, gl, di, dl;
    string p;
    l  = lat_of(i);
    en = 0; we = 0; gi = 0; gl = 0; di = 0; dl = 0;
    if (m_busy[i]) begin
      k  = cyc - m_c0[i];
      en = (k >= 1) && (k <= l);
      we = en && m_wr[i];
      gi = (k == 1) && !m_ls[i];
      gl = (k == 1) && m_ls[i];
      di = (k == l + 1) && !m_ls[i];
      dl = (k == l + 1) && m_ls[i];
    end
    p = $sformatf("lat%0d", l);
    chk({p, ".mem_en"},    16'(mem_en[i]),  16'(en));
    chk({p, ".mem_we"},    16'(mem_we[i]),  16'(we));
    chk({p, ".if_gnt"},    16'(if_gnt[i]),  16'(gi));
    chk({p, ".ls_gnt"},    16'(ls_gnt[i]),  16'(gl));
    chk({p, ".if_done"},   16'(if_done[i]), 16'(di));
    chk({p, ".ls_done"},   16'(ls_done[i]), 16'(dl));
    chk({p, ".mem_addr"},  mem_addr[i],     m_addr[i]);
    chk({p, ".mem_wdata"}, mem_wdata[i],    m_wdata[i]);
    chk({p, ".rd_data"},   rd_data[i],      m_rd[i]);
  endtask

  // One clock: model the edge, then sample 1 time unit later and log transactions.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) check(i);
    for (int i = 0; i < 2; i++) begin
      if (if_gnt[i] || ls_gnt[i])
        $display("[TB] cyc=%0d lat=%0d grant %s addr=%h we=%0d", cyc, lat_of(i),
                 ls_gnt[i] ? "LS" : "IF", mem_addr[i], mem_we[i]);
      if (if_done[i] || ls_done[i])
        $display("[TB] cyc=%0d lat=%0d done  %s rd_data=%h", cyc, lat_of(i),
                 ls_done[i] ? "LS" : "IF", rd_data[i]);
    end
    if (if_gnt[0]) q_gnt0.push_back(1'b0);
    if (ls_gnt[0]) begin q_gnt0.push_back(1'b1); n_ls_gnt0++; end
    if (ls_done[0]) n_ls_done0++;
    if (if_gnt[1])  q_if_gnt1.push_back(cyc);
    if (if_done[1]) q_if_done1.push_back(cyc);
    if (rand_rdata) mem_rdata = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;

    // Reset state.
    tick(); tick();
    chk("reset.mem_en",  16'(mem_en[0]), 16'h0);
    chk("reset.rd_data", rd_data[0],     16'h0000);
    rst = 1'b0;
    tick();

    // Single fetch.
    if_req = 1; if_addr = 16'h0040; mem_rdata = 16'h1234;
    tick();
    if_req = 0;
    chk("fetch.if_gnt_c1",   16'(if_gnt[0]), 16'h1);
    chk("fetch.mem_addr_c1", mem_addr[0],    16'h0040);
    tick();
    chk("fetch.mem_en_c2",   16'(mem_en[0]), 16'h1);
    tick();
    chk("fetch.if_done_c3",  16'(if_done[0]), 16'h1);
    chk("fetch.rd_data_c3",  rd_data[0],      16'h1234);
    tick(); tick();

    // Store, which leaves RD_DATA untouched.
    ls_req = 1; ls_we = 1; ls_addr = 16'h00F0; ls_wdata = 16'hBEEF; mem_rdata = 16'hDEAD;
    tick();
    ls_req = 0; ls_we = 0;
    chk("store.mem_we_c1",    16'(mem_we[0]), 16'h1);
    chk("store.mem_wdata_c1", mem_wdata[0],   16'hBEEF);
    tick(); tick();
    chk("store.ls_done_c3",   16'(ls_done[0]), 16'h1);
    chk("store.rd_data_kept", rd_data[0],      16'h1234);
    tick(); tick();

    // Simultaneous requests held from reset.
    rand_rdata = 1;
    rst = 1; if_req = 1; ls_req = 1; ls_we = 0;
    if_addr = 16'h0100; ls_addr = 16'h0200;
    tick();
    rst = 0;
    q_gnt0.delete();
    for (int n = 0; n < 20; n++) tick();
    chk("tie.grant_count", 16'(q_gnt0.size() >= 4), 16'h1);
    for (int j = 0; j < 4 && j < q_gnt0.size(); j++)
      chk($sformatf("tie.grant%0d_is_ls", j), 16'(q_gnt0[j]), RR ? 16'(j % 2) : 16'h1);
    if_req = 0; ls_req = 0;
    for (int n = 0; n < 5; n++) tick();

    // LS request pulsed while a fetch is in ACCESS.
    n_ls_gnt0 = 0;
    if_req = 1; if_addr = 16'h0300;
    tick();
    if_req = 0; ls_req = 1; ls_addr = 16'h0400;
    tick();
    ls_req = 0;
    for (int n = 0; n < 6; n++) tick();
    chk("busy.no_ls_gnt", 16'(n_ls_gnt0), 16'h0);

    // Reset in the first ACCESS cycle of a load.
    n_ls_done0 = 0;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0500;
    tick();
    ls_req = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_mid.mem_en",  16'(mem_en[0]), 16'h0);
    chk("rst_mid.rd_data", rd_data[0],     16'h0000);
    for (int n = 0; n < 5; n++) tick();
    chk("rst_mid.no_done", 16'(n_ls_done0), 16'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if_req   = 1'($urandom_range(0, 1));
      ls_req   = 1'($urandom_range(0, 1));
      ls_we    = 1'($urandom_range(0, 1));
      if_addr  = 16'($urandom);
      ls_addr  = 16'($urandom);
      ls_wdata = 16'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 0; if_req = 0; ls_req = 0;
    tick(); tick(); tick(); tick();

    // MEM_LAT=1 back-to-back fetches.
    rst = 1;
    tick();
    rst = 0; if_req = 1; if_addr = 16'h0600;
    q_if_gnt1.delete(); q_if_done1.delete();
    for (int n = 0; n < 14; n++) tick();
    if_req = 0;
    tick(); tick();
    chk("lat1.gnt_count", 16'(q_if_gnt1.size() >= 4), 16'h1);
    for (int j = 1; j < q_if_gnt1.size(); j++)
      chk($sformatf("lat1.gnt_gap%0d", j), 16'(q_if_gnt1[j] - q_if_gnt1[j-1]), 16'd3);
    for (int j = 0; j < q_if_gnt1.size() && j < q_if_done1.size(); j++)
      chk($sformatf("lat1.done_lag%0d", j), 16'(q_if_done1[j] - q_if_gnt1[j]), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
